wb_slave_mux: RTL and testbench

Parametrised Wishbone B4 classic single-master to N-slave bus decoder with registered responses, a per-transaction timeout watchdog and a sticky bus-fault capture register. It sits between the core's Wishbone master controller and the peripheral slaves (data/instruction memory, UART, GPIO, CLINT, SPI flash, and future additions). It replaces fixed per-peripheral wiring with an address map set by parameters. It returns a bus error for unmapped addresses and for slaves that never respond, so a missing or hung peripheral cannot stall the pipeline forever.

---
 rtl/wb_slave_mux.sv | 239 +++++++++++++++++++++++
 tb/tb_wb_slave_mux.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mux.sv
// wb_slave_mux
// Wishbone B4 classic decoder that connects one master to N_SLAVES slaves.
// The address map is set by parameters, and responses are registered.
// Unmapped accesses return a bus error.
// A watchdog turns a slave that never answers into a bus error.
// The first bus error after a clear is held in a sticky fault register.
//
// State table
//   state | meaning
//   IDLE  | waiting for cyc&stb; the address is decoded here
//   BUSY  | the selected slave is strobed; waiting for its ack/err or the watchdog
//   RESP  | one-cycle wbm_ack_o; read data is already in wbm_dat_o
//   ERR   | one-cycle wbm_err_o; the fault register was updated on entry
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   wbm_*_i / wbm_*_o   master side (adr/dat/sel/we/cyc/stb in, dat/ack/err out)
//   wbs_*_o             broadcast adr/dat/sel/we, per-slave cyc/stb
//   wbs_*_i             per-slave read data (packed), ack, err
//   fault_clr_i         clears the fault capture register
//   fault_*_o           sticky valid flag, first faulting address, cause
//                       (01 unmapped, 10 timeout, 11 slave error)
module wb_slave_mux #(
  parameter int                       N_SLAVES = 7,
  parameter logic [N_SLAVES*32-1:0]   SLV_BASE = {32'h6000_0000, 32'h5000_0000, 32'h4000_0000,
                                                  32'h3000_0000, 32'h2000_0000, 32'h1000_0000,
                                                  32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]   SLV_MASK = {7{32'hF000_0000}},
  parameter int                       TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             wbm_adr_i,
  input  logic [31:0]             wbm_dat_i,
  input  logic [3:0]              wbm_sel_i,
  input  logic                    wbm_we_i,
  input  logic                    wbm_cyc_i,
  input  logic                    wbm_stb_i,
  output logic [31:0]             wbm_dat_o,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic [31:0]             wbs_adr_o,
  output logic [31:0]             wbs_dat_o,
  output logic [3:0]              wbs_sel_o,
  output logic                    wbs_we_o,
  output logic [N_SLAVES-1:0]     wbs_cyc_o,
  output logic [N_SLAVES-1:0]     wbs_stb_o,
  input  logic [N_SLAVES*32-1:0]  wbs_dat_i,
  input  logic [N_SLAVES-1:0]     wbs_ack_i,
  input  logic [N_SLAVES-1:0]     wbs_err_i,
  input  logic                    fault_clr_i,
  output logic                    fault_valid_o,
  output logic [31:0]             fault_addr_o,
  output logic [1:0]              fault_cause_o
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_SLV_ERR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_W-1:0]     r_sel;
  logic [CNT_W-1:0]     r_cnt;
  logic [31:0]          r_dat;
  logic                 r_fault_valid;
  logic [31:0]          r_fault_addr;
  logic [1:0]           r_fault_cause;

  logic                 w_hit;
  logic [SEL_W-1:0]     w_hit_idx;
  logic                 w_slv_ack;
  logic                 w_slv_err;
  logic [31:0]          w_slv_dat;
  logic [1:0]           w_cause;
  logic                 w_sel_ld;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_dat_ld;
  logic                 w_fault_ld;

  // The loop runs from the highest index down, so the lowest hitting slave
  // is assigned last and wins when entries overlap.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((wbm_adr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        w_hit     = 1'b1;
        w_hit_idx = SEL_W'(i);
      end
    end
  end

  // Response signals of the slave latched in r_sel.
  always_comb begin
    w_slv_ack = 1'b0;
    w_slv_err = 1'b0;
    w_slv_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_slv_ack = wbs_ack_i[i];
        w_slv_err = wbs_err_i[i];
        w_slv_dat = wbs_dat_i[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cause     = 2'b00;
    w_sel_ld    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_dat_ld    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (w_hit) begin
            w_state_nxt = ST_BUSY;
            w_sel_ld    = 1'b1;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = ST_ERR;
            w_cause     = CAUSE_UNMAPPED;
          end
        end
      end
      ST_BUSY: begin
        // If the master abandons the cycle, the slave strobes are dropped
        // and no response is given.
        if (!wbm_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_slv_ack) begin
          w_state_nxt = ST_RESP;
          w_dat_ld    = 1'b1;
        end else if (w_slv_err) begin
          w_state_nxt = ST_ERR;
          w_cause     = CAUSE_SLV_ERR;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_state_nxt = ST_ERR;
          w_cause     = CAUSE_TIMEOUT;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ERR is only ever entered from IDLE or BUSY, so next-state alone marks entry.
  assign w_fault_ld = (w_state_nxt == ST_ERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sel_ld) begin
        r_sel <= w_hit_idx;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_dat_ld) begin
        r_dat <= w_slv_dat;
      end
    end
  end

  // A fault that enters ERR on the same edge as a clear is captured,
  // because the load condition ignores the old valid flag when clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fault_valid <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_cause <= 2'b00;
    end else begin
      if (fault_clr_i) begin
        r_fault_valid <= 1'b0;
        r_fault_addr  <= '0;
        r_fault_cause <= 2'b00;
      end
      if (w_fault_ld && (!r_fault_valid || fault_clr_i)) begin
        r_fault_valid <= 1'b1;
        r_fault_addr  <= wbm_adr_i;
        r_fault_cause <= w_cause;
      end
    end
  end

  // Slave cyc/stb follow the master directly while BUSY, so they fall in the
  // same cycle as a master abort or an asynchronous reset.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (r_state == ST_BUSY) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (r_sel == SEL_W'(i)) begin
          wbs_cyc_o[i] = wbm_cyc_i;
          wbs_stb_o[i] = wbm_stb_i;
        end
      end
    end
  end

  assign wbs_adr_o     = wbm_adr_i;
  assign wbs_dat_o     = wbm_dat_i;
  assign wbs_sel_o     = wbm_sel_i;
  assign wbs_we_o      = wbm_we_i;

  assign wbm_dat_o     = r_dat;
  assign wbm_ack_o     = (r_state == ST_RESP);
  assign wbm_err_o     = (r_state == ST_ERR);

  assign fault_valid_o = r_fault_valid;
  assign fault_addr_o  = r_fault_addr;
  assign fault_cause_o = r_fault_cause;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Testbench for wb_slave_mux.
// The reference model works per transaction. It decodes the address from the
// base/mask table and predicts the response cycle and kind from the slave
// latency. It also keeps the expected sticky fault record and the last read data.
module tb_wb_slave_mux;

  localparam int NS = 4;
  localparam int TO = 8;
  localparam logic [NS*32-1:0] BASES = {32'h2000_0200, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFFFF_FF00, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_F000};

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_NONE = 2;

  logic              clk;
  logic              reset_n;
  logic [31:0]       wbm_adr_i;
  logic [31:0]       wbm_dat_i;
  logic [3:0]        wbm_sel_i;
  logic              wbm_we_i;
  logic              wbm_cyc_i;
  logic              wbm_stb_i;
  logic [31:0]       wbm_dat_o;
  logic              wbm_ack_o;
  logic              wbm_err_o;
  logic [31:0]       wbs_adr_o;
  logic [31:0]       wbs_dat_o;
  logic [3:0]        wbs_sel_o;
  logic              wbs_we_o;
  logic [NS-1:0]     wbs_cyc_o;
  logic [NS-1:0]     wbs_stb_o;
  logic [NS*32-1:0]  wbs_dat_i;
  logic [NS-1:0]     wbs_ack_i;
  logic [NS-1:0]     wbs_err_i;
  logic              fault_clr_i;
  logic              fault_valid_o;
  logic [31:0]       fault_addr_o;
  logic [1:0]        fault_cause_o;

  wb_slave_mux #(
    .N_SLAVES (NS),
    .SLV_BASE (BASES),
    .SLV_MASK (MASKS),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wbm_adr_i     (wbm_adr_i),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_sel_i     (wbm_sel_i),
    .wbm_we_i      (wbm_we_i),
    .wbm_cyc_i     (wbm_cyc_i),
    .wbm_stb_i     (wbm_stb_i),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_ack_o     (wbm_ack_o),
    .wbm_err_o     (wbm_err_o),
    .wbs_adr_o     (wbs_adr_o),
    .wbs_dat_o     (wbs_dat_o),
    .wbs_sel_o     (wbs_sel_o),
    .wbs_we_o      (wbs_we_o),
    .wbs_cyc_o     (wbs_cyc_o),
    .wbs_stb_o     (wbs_stb_o),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_i     (wbs_ack_i),
    .wbs_err_i     (wbs_err_i),
    .fault_clr_i   (fault_clr_i),
    .fault_valid_o (fault_valid_o),
    .fault_addr_o  (fault_addr_o),
    .fault_cause_o (fault_cause_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "time limit");
  end

  int          n_vec;
  int          n_bad;
  logic [31:0] m_base [NS];
  logic [31:0] m_mask [NS];
  logic        m_fv;
  logic [31:0] m_fa;
  logic [1:0]  m_fc;
  logic [31:0] m_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Returns the first table entry whose masked address equals its base, or -1.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic chk_fault(input string tag);
    chk({tag, "_fv"},    32'(fault_valid_o), 32'(m_fv));
    chk({tag, "_faddr"}, fault_addr_o,       m_fa);
    chk({tag, "_fcause"}, 32'(fault_cause_o), 32'(m_fc));
  endtask

  // Call this at a negedge. The request is presented in cycle 0 and sampled at edge 0.
  // For a mapped address, the slave answers in cycle 'lat' (1..TO).
  // With K_NONE the slave never answers.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] wdat, input logic we,
                      input int kind, input int lat, input logic [31:0] rdat, input logic clr);
    int            s;
    int            r;
    logic [NS-1:0] exp_stb;
    s = ref_decode(adr);
    wbm_adr_i   = adr;
    wbm_dat_i   = wdat;
    wbm_sel_i   = 4'($urandom);
    wbm_we_i    = we;
    wbm_cyc_i   = 1'b1;
    wbm_stb_i   = 1'b1;
    fault_clr_i = clr;
    for (int i = 0; i < NS; i++) wbs_dat_i[32*i +: 32] = $urandom;
    if (s >= 0) wbs_dat_i[32*s +: 32] = rdat;
    #1;
    chk("bcast_adr", wbs_adr_o, adr);
    chk("bcast_dat", wbs_dat_o, wdat);
    chk("bcast_sel", 32'(wbs_sel_o), 32'(wbm_sel_i));
    chk("bcast_we",  32'(wbs_we_o), 32'(we));
    chk("c0_stb",    32'(wbs_stb_o), 32'd0);
    if (clr) begin
      m_fv = 1'b0;
      m_fa = '0;
      m_fc = 2'b00;
    end
    r = (s < 0) ? 0 : ((kind == K_NONE) ? TO : lat);
    for (int c = 1; c <= r + 1; c++) begin
      @(negedge clk);
      fault_clr_i = 1'b0;
      exp_stb = '0;
      if (s >= 0 && c <= r) exp_stb[s] = 1'b1;
      chk("stb", 32'(wbs_stb_o), 32'(exp_stb));
      chk("cyc", 32'(wbs_cyc_o), 32'(exp_stb));
      chk("ack", 32'(wbm_ack_o), 32'((c == r + 1) && (s >= 0) && (kind == K_ACK)));
      chk("err", 32'(wbm_err_o), 32'((c == r + 1) && ((s < 0) || (kind != K_ACK))));
      wbs_ack_i = '0;
      wbs_err_i = '0;
      if (s >= 0 && c == lat && c <= r) begin
        if (kind == K_ACK) wbs_ack_i[s] = 1'b1;
        else if (kind == K_ERR) wbs_err_i[s] = 1'b1;
      end
    end
    if (s >= 0 && kind == K_ACK) m_dat = rdat;
    chk("rdat", wbm_dat_o, m_dat);
    if ((s < 0 || kind != K_ACK) && !m_fv) begin
      m_fv = 1'b1;
      m_fa = adr;
      m_fc = (s < 0) ? 2'b01 : ((kind == K_ERR) ? 2'b11 : 2'b10);
    end
    chk_fault("xfer");
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbs_ack_i = '0;
    wbs_err_i = '0;
    @(negedge clk);
    chk("idle_ack", 32'(wbm_ack_o), 32'd0);
    chk("idle_err", 32'(wbm_err_o), 32'd0);
    chk("idle_stb", 32'(wbs_stb_o), 32'd0);
    chk("idle_dat", wbm_dat_o, m_dat);
  endtask

  task automatic clr_pulse();
    fault_clr_i = 1'b1;
    @(negedge clk);
    fault_clr_i = 1'b0;
    m_fv = 1'b0;
    m_fa = '0;
    m_fc = 2'b00;
    chk_fault("clr");
  endtask

  initial begin
    logic [31:0] adr;
    int          pick;
    int          kd;
    n_vec = 0;
    n_bad = 0;
    m_base[0] = 32'h0000_0000; m_mask[0] = 32'hFFFF_F000;
    m_base[1] = 32'h4000_0000; m_mask[1] = 32'hFFFF_0000;
    m_base[2] = 32'h4000_0000; m_mask[2] = 32'hFF00_0000;
    m_base[3] = 32'h2000_0200; m_mask[3] = 32'hFFFF_FF00;
    m_fv = 1'b0; m_fa = '0; m_fc = 2'b00; m_dat = '0;
    reset_n = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    wbs_dat_i = '0; wbs_ack_i = '0; wbs_err_i = '0; fault_clr_i = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack", 32'(wbm_ack_o), 32'd0);
    chk("rst_err", 32'(wbm_err_o), 32'd0);
    chk("rst_dat", wbm_dat_o, 32'd0);
    chk("rst_stb", 32'(wbs_stb_o), 32'd0);
    chk_fault("rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Zero-wait write to slave 3, then a read from slave 0 with 4 wait cycles
    xfer(32'h2000_0204, 32'hDEAD_BEEF, 1'b1, K_ACK, 1, 32'h0BAD_F00D, 1'b0);
    xfer(32'h0000_0010, 32'h0, 1'b0, K_ACK, 4, 32'h1234_5678, 1'b0);
    // Unmapped accesses; the second leaves the first fault in place
    xfer(32'h9000_0000, 32'h0, 1'b0, K_ACK, 1, 32'h0, 1'b0);
    xfer(32'hA000_0000, 32'h0, 1'b0, K_ACK, 1, 32'h0, 1'b0);
    // Timeout after a clear, then clear again
    clr_pulse();
    xfer(32'h2000_0210, 32'h5555_AAAA, 1'b1, K_NONE, 1, 32'h0, 1'b0);
    clr_pulse();
    // An ack on the last allowed cycle beats the watchdog
    xfer(32'h0000_0020, 32'h0, 1'b0, K_ACK, TO, 32'hCAFE_0001, 1'b0);
    // Overlap: 0x4000_0000 hits slaves 1 and 2, so slave 1 must be selected
    xfer(32'h4000_0000, 32'h0, 1'b0, K_ACK, 2, 32'h0111_1111, 1'b0);
    // Slave error on the last allowed cycle reports cause 11
    xfer(32'h4012_3456, 32'h0, 1'b0, K_ERR, TO, 32'h0, 1'b0);
    // A clear and a new unmapped fault on the same edge: the new fault is kept
    xfer(32'hB000_0000, 32'h0, 1'b0, K_ACK, 1, 32'h0, 1'b1);

    // The master drops cyc mid-BUSY: strobes fall immediately and no response follows
    wbm_adr_i = 32'h4000_0000; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(negedge clk);
    chk("abort_stb1", 32'(wbs_stb_o), 32'h2);
    @(negedge clk);
    chk("abort_stb2", 32'(wbs_stb_o), 32'h2);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    #1;
    chk("abort_stb", 32'(wbs_stb_o), 32'd0);
    chk("abort_cyc", 32'(wbs_cyc_o), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_ack", 32'(wbm_ack_o), 32'd0);
      chk("abort_err", 32'(wbm_err_o), 32'd0);
    end
    chk_fault("abort");
    xfer(32'h0000_0ABC, 32'h0, 1'b0, K_ACK, 1, 32'h0A0A_0A0A, 1'b0);

    // Asynchronous reset during BUSY
    wbm_adr_i = 32'h0000_0100; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("prerst_stb", 32'(wbs_stb_o), 32'h1);
    reset_n = 1'b0;
    #1;
    m_fv = 1'b0; m_fa = '0; m_fc = 2'b00; m_dat = '0;
    chk("midrst_stb", 32'(wbs_stb_o), 32'd0);
    chk("midrst_cyc", 32'(wbs_cyc_o), 32'd0);
    chk("midrst_ack", 32'(wbm_ack_o), 32'd0);
    chk("midrst_err", 32'(wbm_err_o), 32'd0);
    chk("midrst_dat", wbm_dat_o, 32'd0);
    chk_fault("midrst");
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xfer(32'h2000_02FC, 32'h1357_9BDF, 1'b1, K_ACK, 3, 32'h2468_ACE0, 1'b0);

    // Randomized transfers
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0:       adr = {20'h00000, 12'($urandom)};
        1:       adr = 32'h2000_0200 | 32'($urandom_range(0, 255));
        2:       adr = {16'h4000, 16'($urandom)};
        3:       adr = {8'h40, 8'($urandom_range(1, 255)), 16'($urandom)};
        default: adr = 32'h8000_0000 | (32'($urandom) & 32'h0FFF_FFFF);
      endcase
      kd = $urandom_range(0, 9);
      xfer(adr, 32'($urandom), 1'($urandom), (kd < 7) ? K_ACK : ((kd < 9) ? K_ERR : K_NONE),
           $urandom_range(1, TO), 32'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
